// File: rtl/sysreg_timer_node.sv
// Timer-group leaf of the system-register star: privilege-checked register file
// with a 64-bit cycle timer, compare match, auto-reload and a level interrupt.
module sysreg_timer_node #(
  parameter int REG_WIDTH = 64,
  parameter int PRIV_MIN  = 2,
  parameter int DENY_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_en,
  input  logic [2:0]           rd_regnum,
  input  logic [1:0]           rd_plevel,
  output logic                 rd_valid,
  output logic [REG_WIDTH-1:0] rd_val,
  input  logic                 wr_en,
  input  logic [2:0]           wr_regnum,
  input  logic [1:0]           wr_plevel,
  input  logic [REG_WIDTH-1:0] wr_val,
  output logic                 irq
);

  localparam logic [2:0] RegCycle   = 3'd0;
  localparam logic [2:0] RegCmp     = 3'd1;
  localparam logic [2:0] RegCtrl    = 3'd2;
  localparam logic [2:0] RegStatus  = 3'd3;
  localparam logic [2:0] RegScratch = 3'd4;
  localparam logic [2:0] RegDenyCnt = 3'd5;
  localparam logic [1:0] PrivMin    = PRIV_MIN[1:0];

  logic [REG_WIDTH-1:0] cycle_q, cycle_d;
  logic [REG_WIDTH-1:0] cmp_q, cmp_d;
  logic [2:0]           ctrl_q, ctrl_d;
  logic                 pend_q, pend_d;
  logic                 denied_q, denied_d;
  logic [REG_WIDTH-1:0] scratch_q, scratch_d;
  logic [DENY_W-1:0]    denyCnt_q, denyCnt_d;
  logic                 rdValid_q;
  logic [REG_WIDTH-1:0] rdVal_q, rdMux;
  logic                 irq_q;

  logic wrAllowed, wrOk, denyHit, matchHit;

  // Reads are never privilege-checked, so the read plevel carries no information here.
  logic unusedRdPlevel;
  assign unusedRdPlevel = ^rd_plevel;

  always_comb begin
    wrAllowed = 1'b1;
    case (wr_regnum)
      RegCycle, RegCmp, RegCtrl, RegStatus: wrAllowed = (wr_plevel >= PrivMin);
      RegDenyCnt:                           wrAllowed = (wr_plevel == 2'd3);
      default:                              wrAllowed = 1'b1;
    endcase
    wrOk     = wr_en & wrAllowed;
    denyHit  = wr_en & ~wrAllowed;
    matchHit = ctrl_q[0] & (cycle_q == cmp_q);
  end

  always_comb begin
    rdMux = '0;
    case (rd_regnum)
      RegCycle:   rdMux = cycle_q;
      RegCmp:     rdMux = cmp_q;
      RegCtrl:    rdMux = {{(REG_WIDTH-3){1'b0}}, ctrl_q};
      RegStatus:  rdMux = {{(REG_WIDTH-2){1'b0}}, denied_q, pend_q};
      RegScratch: rdMux = scratch_q;
      RegDenyCnt: rdMux = {{(REG_WIDTH-DENY_W){1'b0}}, denyCnt_q};
      default:    rdMux = '0;
    endcase
  end

  // Software writes to CYCLE and set-on-match for PEND take priority over the
  // competing update in the same cycle.
  always_comb begin
    cycle_d   = cycle_q;
    cmp_d     = cmp_q;
    ctrl_d    = ctrl_q;
    pend_d    = pend_q;
    denied_d  = denied_q;
    scratch_d = scratch_q;
    denyCnt_d = denyCnt_q;

    if (ctrl_q[0]) begin
      cycle_d = (matchHit && ctrl_q[2]) ? '0 : cycle_q + REG_WIDTH'(1);
    end

    if (wrOk) begin
      case (wr_regnum)
        RegCycle:   cycle_d   = wr_val;
        RegCmp:     cmp_d     = wr_val;
        RegCtrl:    ctrl_d    = wr_val[2:0];
        RegStatus: begin
          if (wr_val[0]) pend_d   = 1'b0;
          if (wr_val[1]) denied_d = 1'b0;
        end
        RegScratch: scratch_d = wr_val;
        RegDenyCnt: denyCnt_d = '0;
        default:    ;
      endcase
    end

    if (matchHit) pend_d = 1'b1;

    if (denyHit) begin
      denied_d = 1'b1;
      if (denyCnt_q != '1) denyCnt_d = denyCnt_q + DENY_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q   <= '0;
      cmp_q     <= '0;
      ctrl_q    <= '0;
      pend_q    <= 1'b0;
      denied_q  <= 1'b0;
      scratch_q <= '0;
      denyCnt_q <= '0;
      rdValid_q <= 1'b0;
      rdVal_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      cycle_q   <= cycle_d;
      cmp_q     <= cmp_d;
      ctrl_q    <= ctrl_d;
      pend_q    <= pend_d;
      denied_q  <= denied_d;
      scratch_q <= scratch_d;
      denyCnt_q <= denyCnt_d;
      rdValid_q <= rd_en;
      if (rd_en) rdVal_q <= rdMux;
      irq_q     <= pend_d & ctrl_d[1];
    end
  end

  assign rd_valid = rdValid_q;
  assign rd_val   = rdVal_q;
  assign irq      = irq_q;

endmodule
